// File: rtl/hht_control.sv
// hht_control: helper-thread front end that gathers v[col[i]] for CSR SpMV
// into a small FIFO which the CPU drains through loads from HHT_ADDR.
module hht_control #(
    parameter int HHT_ADDR  = 126,
    parameter int DEPTH     = 16,
    parameter int REG_COL   = 6,
    parameter int REG_VBASE = 8,
    parameter int REG_ROW   = 15,
    parameter int REG_MAT   = 9
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] base_dat_a,
    input  logic [31:0] base_dat_b,
    output logic [31:0] addr1,
    output logic [31:0] addr2,
    input  logic [31:0] dataIn1,
    input  logic [31:0] dataIn2,
    input  logic        RD,
    input  logic [31:0] csize,
    input  logic [31:0] cpu_addr,
    output logic        hht,
    output logic [4:0]  regaddr1,
    output logic [4:0]  regaddr2,
    output logic [4:0]  rdata,
    output logic [4:0]  adata
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CFG_A,
        CFG_B,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0] col_base;
    logic [31:0] row_base;
    logic [31:0] v_base;
    logic [31:0] mat_base;

    logic [31:0] idx;
    logic        in_flight;
    logic [31:0] addr1_q;

    logic [31:0] buf_mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [4:0]  occ;
    logic [31:0] pop_data;

    logic more;
    logic credit;
    logic issue;
    logic push;
    logic pop;
    logic drained;

    // Row/matrix bases belong to a later stage; they are only captured here.
    logic unused_taps;
    assign unused_taps = ^{row_base, mat_base, pop_data};

    assign more    = idx < csize;
    assign credit  = (32'(occ) + 32'(in_flight)) < 32'(DEPTH);
    assign issue   = (state == RUN) && more && credit;
    assign push    = in_flight;
    assign pop     = RD && (cpu_addr == 32'(HHT_ADDR)) && (occ != 5'd0);
    assign drained = (idx == csize) && !in_flight &&
                     ((occ == 5'd0) || ((occ == 5'd1) && pop));

    assign pop_data = buf_mem[rptr];
    assign rdata    = occ;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= CFG_A;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CFG_A: state_nx = CFG_B;
            CFG_B: state_nx = (csize == 32'd0) ? DONE : RUN;
            RUN:   if (drained) state_nx = DONE;
            DONE:  state_nx = DONE;
            default: state_nx = CFG_A;
        endcase
    end

    always_comb begin
        regaddr1 = 5'(REG_VBASE);
        regaddr2 = 5'(REG_MAT);
        hht      = 1'b0;
        addr1    = addr1_q;
        unique case (state)
            CFG_A: begin
                regaddr1 = 5'(REG_COL);
                regaddr2 = 5'(REG_ROW);
            end
            RUN: begin
                hht = 1'b1;
                if (more) addr1 = col_base + idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_base <= '0;
            row_base <= '0;
            v_base   <= '0;
            mat_base <= '0;
        end else if (state == CFG_A) begin
            col_base <= base_dat_a;
            row_base <= base_dat_b;
        end else if (state == CFG_B) begin
            v_base   <= base_dat_a;
            mat_base <= base_dat_b;
        end
    end

    // addr1 keeps showing the last issued column address once i reaches csize.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            idx       <= '0;
            in_flight <= 1'b0;
            addr1_q   <= '0;
            addr2     <= '0;
            adata     <= '0;
        end else begin
            addr1_q   <= addr1;
            in_flight <= issue;
            if (issue) begin
                addr2 <= v_base + dataIn1;
                adata <= dataIn1[4:0];
                idx   <= idx + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + 5'd1;
                2'b01:   occ <= occ - 5'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) buf_mem[wptr] <= dataIn2;
    end

endmodule

// File: tb/tb_hht_control.sv
// tb_hht_control: directed + randomized checks of hht_control against a
// queue-based model of the gather/drain behaviour.
module tb_hht_control;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] base_dat_a, base_dat_b;
    logic [31:0] addr1, addr2;
    logic [31:0] dataIn1, dataIn2;
    logic        RD;
    logic [31:0] csize, cpu_addr;
    logic        hht;
    logic [4:0]  regaddr1, regaddr2, rdata, adata;

    logic [31:0] mem  [256];
    logic [31:0] regs [32];

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] COLB = 32'd180;
    localparam logic [31:0] VB   = 32'd2;

    // model state
    int          phase;
    int unsigned m_i;
    bit          m_inf;
    logic [31:0] m_inf_val, m_addr2, m_a1_last;
    logic [4:0]  m_adata;
    logic [31:0] m_q[$];

    always #5 Clk = ~Clk;

    assign base_dat_a = regs[regaddr1];
    assign base_dat_b = regs[regaddr2];
    assign dataIn1    = mem[addr1[7:0]];
    assign dataIn2    = mem[addr2[7:0]];

    hht_control dut (
        .Clk(Clk), .Rst(Rst),
        .base_dat_a(base_dat_a), .base_dat_b(base_dat_b),
        .addr1(addr1), .addr2(addr2),
        .dataIn1(dataIn1), .dataIn2(dataIn2),
        .RD(RD), .csize(csize), .cpu_addr(cpu_addr),
        .hht(hht), .regaddr1(regaddr1), .regaddr2(regaddr2),
        .rdata(rdata), .adata(adata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        phase     = 0;
        m_i       = 0;
        m_inf     = 0;
        m_inf_val = '0;
        m_addr2   = '0;
        m_a1_last = '0;
        m_adata   = '0;
        m_q.delete();
    endfunction

    task automatic step(input bit rst_in, input bit rd_in,
                        input logic [31:0] ca);
        logic [31:0] e_a1, c;
        bit lt, iss, pp;
        @(negedge Clk);
        Rst = rst_in;
        RD = rd_in;
        cpu_addr = ca;
        #1;
        lt   = m_i < csize;
        e_a1 = (phase == 2 && lt) ? COLB + m_i : m_a1_last;
        chk("hht", 32'(hht), 32'(phase == 2));
        chk("regaddr1", 32'(regaddr1), (phase == 0) ? 32'd6 : 32'd8);
        chk("regaddr2", 32'(regaddr2), (phase == 0) ? 32'd15 : 32'd9);
        chk("addr1", addr1, e_a1);
        chk("addr2", addr2, m_addr2);
        chk("adata", 32'(adata), 32'(m_adata));
        chk("rdata", 32'(rdata), 32'(m_q.size()));
        pp = rd_in && ca == 32'd126 && m_q.size() > 0;
        if (pp) chk("pop_data", dut.pop_data, m_q[0]);
        if (rst_in) begin
            model_reset();
            return;
        end
        m_a1_last = e_a1;
        case (phase)
            0: phase = 1;
            1: phase = (csize == 0) ? 3 : 2;
            2: begin
                iss = lt && (m_q.size() + int'(m_inf) < 16);
                if (pp) void'(m_q.pop_front());
                if (m_inf) m_q.push_back(m_inf_val);
                if (m_i == csize && !m_inf && m_q.size() == 0) phase = 3;
                m_inf = iss;
                if (iss) begin
                    c         = mem[8'((COLB + m_i) & 32'hff)];
                    m_addr2   = VB + c;
                    m_adata   = c[4:0];
                    m_inf_val = mem[m_addr2[7:0]];
                    m_i++;
                end
            end
            default: ;
        endcase
    endtask

    // mode 0: RD low, 1: RD high, 2: random RD and occasional wrong address
    task automatic run_cycles(input int n, input int mode);
        bit r;
        logic [31:0] ca;
        for (int k = 0; k < n; k++) begin
            r  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
            ca = (mode == 2 && $urandom_range(0, 3) == 0) ? 32'd125 : 32'd126;
            step(1'b0, r, ca);
        end
    endtask

    initial begin
        logic [31:0] vinit [16];
        vinit = '{55, 1, 0, 97, 10, 67, 66, 54, 3, 25, 25, 95, 16, 28, 91, 67};
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        for (int k = 0; k < 51; k++) mem[180 + k] = $urandom_range(0, 40);
        mem[180] = 0;
        mem[181] = 5;
        mem[182] = 7;
        mem[183] = 10;
        for (int k = 0; k < 16; k++) mem[2 + k] = vinit[k];
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        regs[6] = COLB;
        regs[8] = VB;
        csize = 32'd51;
        RD = 1'b1;
        cpu_addr = 32'd126;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        model_reset();

        // config fetch, gather and completion with RD held high
        step(1'b1, 1'b1, 32'd126);
        step(1'b0, 1'b1, 32'd126);
        chk("c0_regaddr1", 32'(regaddr1), 32'd6);
        chk("c0_regaddr2", 32'(regaddr2), 32'd15);
        step(1'b0, 1'b1, 32'd126);
        chk("c1_regaddr1", 32'(regaddr1), 32'd8);
        chk("c1_regaddr2", 32'(regaddr2), 32'd9);
        step(1'b0, 1'b1, 32'd126);
        chk("c2_addr1", addr1, 32'd180);
        chk("c2_hht", 32'(hht), 32'd1);
        step(1'b0, 1'b1, 32'd126);
        chk("c3_addr2", addr2, 32'd2);
        step(1'b0, 1'b1, 32'd126);
        chk("c4_addr2", addr2, 32'd7);
        chk("c4_pop", dut.pop_data, 32'd55);
        run_cycles(200, 1);
        chk("done_addr1", addr1, 32'd230);
        chk("done_hht", 32'(hht), 32'd0);
        chk("done_rdata", 32'(rdata), 32'd0);

        // backpressure then random draining
        step(1'b1, 1'b0, 32'd126);
        run_cycles(40, 0);
        chk("full_rdata", 32'(rdata), 32'd16);
        chk("full_addr1", addr1, 32'd196);
        step(1'b0, 1'b1, 32'd126);
        chk("bp_pop0", dut.pop_data, 32'd55);
        step(1'b0, 1'b1, 32'd126);
        chk("bp_pop1", dut.pop_data, 32'd67);
        run_cycles(400, 2);
        chk("bp_done_hht", 32'(hht), 32'd0);
        chk("bp_done_addr1", addr1, 32'd230);

        // csize == 0 goes straight to DONE
        csize = 32'd0;
        step(1'b1, 1'b1, 32'd126);
        run_cycles(3, 1);
        chk("z_hht", 32'(hht), 32'd0);
        chk("z_addr2", addr2, 32'd0);
        chk("z_addr1", addr1, 32'd0);
        run_cycles(5, 1);

        // reset in the middle of a run
        csize = 32'd51;
        step(1'b1, 1'b0, 32'd126);
        run_cycles(20, 0);
        step(1'b1, 1'b0, 32'd126);
        step(1'b0, 1'b1, 32'd126);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_hht", 32'(hht), 32'd0);
        chk("rst_addr2", addr2, 32'd0);
        run_cycles(2, 1);
        chk("rst_c2_addr1", addr1, 32'd180);
        run_cycles(400, 2);
        chk("rst_done_hht", 32'(hht), 32'd0);

        // random length run
        csize = 32'($urandom_range(1, 50));
        step(1'b1, 1'b1, 32'd126);
        run_cycles(400, 2);
        chk("rnd_done_hht", 32'(hht), 32'd0);
        chk("rnd_done_addr1", addr1, COLB + csize - 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hht_control.md
# hht_control

Hardware helper thread (HHT) front end for CSR sparse matrix–vector multiply. After reset it fetches its base addresses from the register file. It then walks the column-index array and gathers `v[col[i]]` for `i = 0..csize-1` into an internal FIFO. The CPU consumes the FIFO by issuing reads to a dedicated HHT address. It sits between the register file, two memory read ports and the CPU load path.

## Interface
- `HHT_ADDR`, 126: CPU load address that pops the buffer.
- `DEPTH`, 16: buffer entries.
- `REG_COL`, 6: register holding column-array base.
- `REG_VBASE`, 8: register holding vector base.
- `REG_ROW`, 15: register holding row-pointer base.
- `REG_MAT`, 9: register holding matrix-value base.

One clock; reset is synchronous and active-high. Clock is `Clk`, reset is `Rst`.

- `Clk` in 1: clock, rising edge.
- `Rst` in 1: synchronous active-high reset.
- `base_dat_a` in 32: register-file data for `regaddr1`, combinational same cycle.
- `base_dat_b` in 32: register-file data for `regaddr2`, combinational same cycle.
- `addr1` out 32: column-array read address.
- `addr2` out 32: vector read address.
- `dataIn1` in 32: memory data for `addr1`, combinational same cycle.
- `dataIn2` in 32: memory data for `addr2`, combinational same cycle.
- `RD` in 1: CPU read strobe.
- `csize` in 32: number of nonzeros (column entries).
- `cpu_addr` in 32: CPU load address.
- `hht` out 1: engine active.
- `regaddr1` out 5: register-file read index, port A.
- `regaddr2` out 5: register-file read index, port B.
- `rdata` out 5: buffer occupancy, 0..16.
- `adata` out 5: column index of the most recent gather issue.

## Operation
- FSM states are CFG_A → CFG_B → RUN → DONE.
- **CFG_A**
  - Drives `regaddr1=REG_COL` and `regaddr2=REG_ROW`.
  - At the clock edge it latches `col_base<=base_dat_a` and `row_base<=base_dat_b`.
- **CFG_B**
  - Drives `regaddr1=REG_VBASE` and `regaddr2=REG_MAT`.
  - At the clock edge it latches `v_base` and `mat_base`.
  - If `csize==0` the next state is DONE; otherwise it is RUN.
  - `row_base` and `mat_base` are stored only. X on these inputs must not corrupt anything.
- **RUN**, two-stage gather pipeline.
  - Issue stage: `addr1 = col_base + i` (combinational). Issue happens when `i < csize` and `occupancy + in_flight < DEPTH`.
  - On issue, at the edge: `addr2 <= v_base + dataIn1`, `adata <= dataIn1[4:0]`, `i <= i+1`, and the in_flight flag is set.
  - Push stage: the cycle after an issue, `dataIn2` is written into the FIFO at the edge.
- **Pop**
  - A pop occurs when `RD==1`, `cpu_addr==HHT_ADDR` and occupancy > 0. The head entry is removed at the edge.
  - The popped value goes to the downstream datapath through the buffer read port; it is not a top-level port.
- **RUN → DONE** when `i==csize`, no issue is in flight, and the FIFO is empty after the current pop.
- **DONE** holds until reset. In DONE, `addr1` holds its last value and `regaddr1/2` hold the CFG_B values.
- **Arithmetic**: address sums are 32-bit modulo 2^32. `dataIn1` is not range-checked.
- **Push and pop in the same cycle**: occupancy is unchanged and FIFO order is preserved.
- **Full**: issue stalls; `i` and `addr1` hold.
- **Empty with a pop request**: ignored; no underflow.

## Timing
- **Reset values**: state=CFG_A, `regaddr1=6`, `regaddr2=15`, `addr1=0`, `addr2=0`, `hht=0`, `rdata=0`, `adata=0`, `i=0`, FIFO empty.
- Reset taken mid-RUN discards the FIFO and all in-flight data, and restarts at CFG_A on the next cycle.
- **Cycle numbering** counts cycles after the first edge with `Rst=0`:
  - c0: CFG_A.
  - c1: CFG_B.
  - c2: first RUN cycle; `addr1=col_base`.
- `hht=1` throughout RUN. It is 0 in CFG_A, CFG_B and DONE.
- **Latencies**
  - Issue to `addr2` valid: 1 cycle.
  - `addr2` to FIFO write: 1 cycle.
  - `rdata` reflects the push one cycle after the `dataIn2` cycle.
- **Throughput**: one element per cycle when not full.

## Test plan
- **Config fetch.** Drive reg6=180, reg8=2, `csize`=51, `RD=1`, `cpu_addr`=126.
  - c0 shows regaddr 6/15 and c1 shows 8/9.
  - c2 shows `addr1=180`, `hht=1`.
- **Gather sequence.** Memory holds col[180..]=0,5,7,10 and v[2..17]=55,1,0,97,10,67,66,54,3,25,25,95,16,28,91,67.
  - `addr2` is 2,7,9,12.
  - Pushed values are 55,67,54,25.
  - `adata` is 0,5,7,10.
- **Completion.** With the setup above, after 51 issues and pops, `addr1` stops at 230 and `hht` falls. No further pushes occur.
- **Backpressure.** Same setup with `RD=0`.
  - `rdata` saturates at 16 and `addr1` stalls at 196.
  - Raise `RD`: the next pops return FIFO order 55,67,….
- **`csize=0`.** `hht` stays 0, state reaches DONE at c2, and no `addr2` activity occurs.
- **Reset mid-run.** Assert `Rst` at c20.
  - Next cycle: all outputs at reset values and `rdata=0`.
  - After release: the sequence restarts at `addr1=180`.
